// File: rtl/timer_pkg.sv
// Shared types and helpers for the MM:SS BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX_ONES     = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit, input logic [3:0] max_val);
    return (digit > max_val) ? max_val : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter: decrements on borrow_in_i, wraps to WRAP on underflow.
module bcd_digit_down #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic [3:0] digit_i,
  input  logic       borrow_in_i,
  output logic [3:0] digit_next_o,
  output logic       borrow_out_o
);

  always_comb begin
    digit_next_o = digit_i;
    borrow_out_o = 1'b0;
    if (borrow_in_i) begin
      if (digit_i == 4'd0) begin
        digit_next_o = WRAP;
        borrow_out_o = 1'b1;
      end else begin
        digit_next_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// MM:SS packed-BCD countdown timer with preset load, pause/resume, restart and a done pulse.
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int MAX_MIN_TENS = 9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [7:0] preset_min_i,
  input  logic [7:0] preset_sec_i,
  input  logic       start_i,
  input  logic       stop_i,
  output logic [7:0] min_bcd_o,
  output logic [7:0] sec_bcd_o,
  output logic       running_o,
  output logic       done_o
);

  localparam logic [3:0] MAX_MT = 4'(MAX_MIN_TENS);

  timer_state_t state_q, state_d;
  logic [7:0]   min_q, min_d, sec_q, sec_d;
  logic [7:0]   pmin_q, pmin_d, psec_q, psec_d;
  logic         running_q, running_d, done_q, done_d;

  logic [7:0] min_dec, sec_dec;
  logic       b_so, b_st, b_mo, b_mt;
  logic [7:0] clamp_min, clamp_sec;

  // Borrow chain: seconds ones -> seconds tens -> minutes ones -> minutes tens.
  bcd_digit_down #(.WRAP(BCD_MAX_ONES)) u_sec_ones (
    .digit_i(sec_q[3:0]), .borrow_in_i(1'b1), .digit_next_o(sec_dec[3:0]), .borrow_out_o(b_so));
  bcd_digit_down #(.WRAP(BCD_MAX_SEC_TENS)) u_sec_tens (
    .digit_i(sec_q[7:4]), .borrow_in_i(b_so), .digit_next_o(sec_dec[7:4]), .borrow_out_o(b_st));
  bcd_digit_down #(.WRAP(BCD_MAX_ONES)) u_min_ones (
    .digit_i(min_q[3:0]), .borrow_in_i(b_st), .digit_next_o(min_dec[3:0]), .borrow_out_o(b_mo));
  bcd_digit_down #(.WRAP(BCD_MAX_ONES)) u_min_tens (
    .digit_i(min_q[7:4]), .borrow_in_i(b_mo), .digit_next_o(min_dec[7:4]), .borrow_out_o(b_mt));

  assign clamp_min = {bcd_clamp(preset_min_i[7:4], MAX_MT), bcd_clamp(preset_min_i[3:0], BCD_MAX_ONES)};
  assign clamp_sec = {bcd_clamp(preset_sec_i[7:4], BCD_MAX_SEC_TENS), bcd_clamp(preset_sec_i[3:0], BCD_MAX_ONES)};

  // Strobe priority is load > stop > start > tick; start in RUN falls through to tick.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pmin_d  = pmin_q;
    psec_d  = psec_q;
    done_d  = 1'b0;
    if (load_i) begin
      min_d   = clamp_min;
      sec_d   = clamp_sec;
      pmin_d  = clamp_min;
      psec_d  = clamp_sec;
      state_d = IDLE;
    end else if (stop_i) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start_i && state_q != RUN) begin
      case (state_q)
        IDLE, PAUSE: if ({min_q, sec_q} != 16'h0000) state_d = RUN;
        EXPIRED: begin
          if ({pmin_q, psec_q} != 16'h0000) begin
            min_d   = pmin_q;
            sec_d   = psec_q;
            state_d = RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (tick_i && state_q == RUN && !b_mt) begin
      // b_mt set means the count was already 00:00, so the decrement is suppressed.
      min_d = min_dec;
      sec_d = sec_dec;
      if ({min_dec, sec_dec} == 16'h0000) begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      pmin_q    <= 8'h00;
      psec_q    <= 8'h00;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pmin_q    <= pmin_d;
      psec_q    <= psec_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign min_bcd_o = min_q;
  assign sec_bcd_o = sec_q;
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd with hand-computed MM:SS expectations.
module tb_countdown_timer_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] presetMin = 8'h00, presetSec = 8'h00;
  logic [7:0] minBcd, secBcd;
  logic       running, done;

  int errorCount = 0;
  int checkCount = 0;

  countdown_timer_bcd #(.MAX_MIN_TENS(9)) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .load_i(load),
    .preset_min_i(presetMin), .preset_sec_i(presetSec),
    .start_i(start), .stop_i(stop),
    .min_bcd_o(minBcd), .sec_bcd_o(secBcd),
    .running_o(running), .done_o(done)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given strobes; outputs are stable when it returns.
  task automatic applyStimulus(input logic ld, input logic [7:0] pm, input logic [7:0] ps,
                               input logic st, input logic sp, input logic tk);
    @(negedge clk);
    load = ld; presetMin = pm; presetSec = ps; start = st; stop = sp; tick = tk;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic doLoad(input logic [7:0] pm, input logic [7:0] ps);
    applyStimulus(1'b1, pm, ps, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doStart();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doIdle();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doTick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    #25;
    checkOutput("reset_count", {minBcd, secBcd}, 32'h0000);
    checkOutput("reset_running", running, 0);
    checkOutput("reset_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    doLoad(8'h10, 8'h00);
    doStart();
    doIdle();
    doTick();
    checkOutput("borrow_10_00", {minBcd, secBcd}, 32'h0959);
    doIdle();

    doLoad(8'h01, 8'h00);
    doStart();
    doTick();
    checkOutput("borrow_01_00", {minBcd, secBcd}, 32'h0059);
    doIdle();

    doLoad(8'h00, 8'h00);
    doStart();
    checkOutput("start_zero_ignored", running, 0);

    doLoad(8'h00, 8'h03);
    checkOutput("load_idle_running", running, 0);
    doStart();
    checkOutput("start_running", running, 1);
    doTick();
    checkOutput("term_t1", {minBcd, secBcd}, 32'h0002);
    doIdle();
    doTick();
    checkOutput("term_t2", {minBcd, secBcd}, 32'h0001);
    checkOutput("term_t2_done", done, 0);
    doIdle();
    doTick();
    checkOutput("term_t3", {minBcd, secBcd}, 32'h0000);
    checkOutput("term_done_high", done, 1);
    checkOutput("term_expired_running", running, 0);
    doIdle();
    checkOutput("term_done_low", done, 0);
    doTick();
    checkOutput("term_extra_tick", {minBcd, secBcd}, 32'h0000);
    checkOutput("term_no_second_done", done, 0);

    doLoad(8'h00, 8'h10);
    doStart();
    doTick();
    doIdle();
    doTick();
    checkOutput("pause_pre", {minBcd, secBcd}, 32'h0008);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("pause_running", running, 0);
    for (int i = 0; i < 5; i++) begin
      doIdle();
      doTick();
    end
    checkOutput("pause_hold", {minBcd, secBcd}, 32'h0008);
    doStart();
    checkOutput("resume_running", running, 1);
    doTick();
    checkOutput("resume_tick", {minBcd, secBcd}, 32'h0007);

    doLoad(8'hAF, 8'h7C);
    checkOutput("clamp", {minBcd, secBcd}, 32'h9959);

    doLoad(8'h00, 8'h02);
    doStart();
    doTick();
    doIdle();
    doTick();
    checkOutput("restart_done", done, 1);
    doStart();
    checkOutput("restart_count", {minBcd, secBcd}, 32'h0002);
    checkOutput("restart_running", running, 1);

    doLoad(8'h00, 8'h06);
    doStart();
    doTick();
    checkOutput("sim_pre", {minBcd, secBcd}, 32'h0005);
    doIdle();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("stop_tick_count", {minBcd, secBcd}, 32'h0005);
    checkOutput("stop_tick_running", running, 0);

    doLoad(8'h00, 8'h02);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("start_tick_not_counted", {minBcd, secBcd}, 32'h0002);
    doIdle();
    doTick();
    checkOutput("load_tick_pre", {minBcd, secBcd}, 32'h0001);
    doIdle();
    applyStimulus(1'b1, 8'h00, 8'h20, 1'b0, 1'b0, 1'b1);
    checkOutput("load_tick_count", {minBcd, secBcd}, 32'h0020);
    checkOutput("load_tick_no_done", done, 0);
    checkOutput("load_tick_idle", running, 0);

    doLoad(8'h01, 8'h30);
    doStart();
    checkOutput("rst_pre_running", running, 1);
    #4;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_count", {minBcd, secBcd}, 32'h0000);
    checkOutput("rst_async_running", running, 0);
    checkOutput("rst_async_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    doStart();
    checkOutput("rst_preset_cleared", running, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
